// File: rtl/opcode_key_driver.sv
// Converts a 4-bit ALU opcode request into a timed active-high key press followed by a release gap.
// Optional echo check of opcode_fb against the captured opcode is compiled in with OPKEY_ECHO_CHECK_EN.
module opcode_key_driver #(
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [3:0] req_opcode,
`ifdef OPKEY_ECHO_CHECK_EN
  input  logic [3:0] opcode_fb,
  output logic       mismatch,
`endif
  output logic       req_ready,
  output logic [3:0] key,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  localparam logic [7:0] PRESS_LOAD = 8'(PRESS_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       ready_q;
  logic       accept;
  logic       legal;
  logic [3:0] pattern;
`ifdef OPKEY_ECHO_CHECK_EN
  logic [3:0] op_q;
`endif

  // Returns {legal, key pattern}; opcodes 10..15 map to an illegal, empty pattern.
  function automatic logic [4:0] map_key(input logic [3:0] op);
    case (op)
      4'd0:    map_key = 5'b1_0001;
      4'd1:    map_key = 5'b1_0010;
      4'd2:    map_key = 5'b1_0100;
      4'd3:    map_key = 5'b1_1000;
      4'd4:    map_key = 5'b1_0101;
      4'd5:    map_key = 5'b1_0011;
      4'd6:    map_key = 5'b1_0110;
      4'd7:    map_key = 5'b1_1100;
      4'd8:    map_key = 5'b1_0111;
      4'd9:    map_key = 5'b1_1110;
      default: map_key = 5'b0_0000;
    endcase
  endfunction

  // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
  always_comb begin
    accept           = req_valid & ready_q;
    {legal, pattern} = map_key(req_opcode);
  end

  // NOTE: the single clocked process uses <= only; all flops (no memories here) are reset so outputs are defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      key     <= 4'b0000;
      done    <= 1'b0;
      err     <= 1'b0;
      ready_q <= 1'b0;
`ifdef OPKEY_ECHO_CHECK_EN
      op_q     <= 4'd0;
      mismatch <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
`ifdef OPKEY_ECHO_CHECK_EN
      mismatch <= 1'b0;
`endif
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (legal) begin
              state   <= PRESS;
              cnt     <= PRESS_LOAD;
              key     <= pattern;
              ready_q <= 1'b0;
`ifdef OPKEY_ECHO_CHECK_EN
              op_q    <= req_opcode;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end
        PRESS: begin
          if (cnt == 8'd0) begin
            state <= GAP;
            cnt   <= GAP_LOAD;
            key   <= 4'b0000;
`ifdef OPKEY_ECHO_CHECK_EN
            mismatch <= (opcode_fb != op_q);
`endif
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          if (cnt == 8'd0) begin
            state   <= IDLE;
            done    <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= 8'd0;
          key     <= 4'b0000;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_opcode_key_driver.sv
// Self-checking bench for opcode_key_driver: expected per-cycle outputs are queued when a request is
// driven and compared one entry per clock; define OPKEY_ECHO_CHECK_EN to also exercise mismatch.
module tb_opcode_key_driver;

  typedef struct packed {
    logic [3:0] key;
    logic       busy;
    logic       done;
    logic       ready;
    logic       err;
    logic       mm_chk;
    logic       mm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_valid1;
  logic [3:0] req_opcode, req_opcode1;
  logic       req_ready, req_ready1;
  logic [3:0] key, key1;
  logic       busy, busy1, done, done1, err, err1;
  logic [3:0] opcode_fb, opcode_fb1;
  logic       mismatch, mismatch1;

  int tests = 0;
  int fails = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  opcode_key_driver u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_opcode(req_opcode),
`ifdef OPKEY_ECHO_CHECK_EN
    .opcode_fb(opcode_fb), .mismatch(mismatch),
`endif
    .req_ready(req_ready), .key(key), .busy(busy), .done(done), .err(err)
  );

  opcode_key_driver #(.PRESS_CYCLES(1), .GAP_CYCLES(1)) u_small (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_opcode(req_opcode1),
`ifdef OPKEY_ECHO_CHECK_EN
    .opcode_fb(opcode_fb1), .mismatch(mismatch1),
`endif
    .req_ready(req_ready1), .key(key1), .busy(busy1), .done(done1), .err(err1)
  );

`ifndef OPKEY_ECHO_CHECK_EN
  assign mismatch  = 1'b0;
  assign mismatch1 = 1'b0;
`endif

  function automatic logic [3:0] ref_key(input logic [3:0] op);
    case (op)
      4'd0: ref_key = 4'b0001;  4'd1: ref_key = 4'b0010;
      4'd2: ref_key = 4'b0100;  4'd3: ref_key = 4'b1000;
      4'd4: ref_key = 4'b0101;  4'd5: ref_key = 4'b0011;
      4'd6: ref_key = 4'b0110;  4'd7: ref_key = 4'b1100;
      4'd8: ref_key = 4'b0111;  4'd9: ref_key = 4'b1110;
      default: ref_key = 4'b0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int which, input exp_t e);
    if (which == 0) q0.push_back(e);
    else            q1.push_back(e);
  endtask

  // Press entries, gap entries, then the done cycle; mm applies to the cycle after the last press.
  task automatic push_seq(input int which, input logic [3:0] op, input int p, input int g,
                          input logic mmc, input logic mm);
    for (int i = 0; i < p; i++) push(which, '{ref_key(op), 1'b1, 1'b0, 1'b0, 1'b0, mmc, 1'b0});
    for (int i = 0; i < g; i++) push(which, '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, mmc, (i == 0) ? mm : 1'b0});
    push(which, '{4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, mmc, 1'b0});
  endtask

  task automatic check_next(input int which);
    exp_t e;
    string w;
    w = (which == 0) ? "dut" : "small";
    check($sformatf("%s_queue_has_entry", w), 8'((which == 0) ? (q0.size() > 0) : (q1.size() > 0)), 8'd1);
    if ((which == 0 && q0.size() > 0) || (which == 1 && q1.size() > 0)) begin
      e = (which == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("%s_key@%0t", w, $time), 8'((which == 0) ? key : key1), 8'(e.key));
      check($sformatf("%s_busy@%0t", w, $time), 8'((which == 0) ? busy : busy1), 8'(e.busy));
      check($sformatf("%s_done@%0t", w, $time), 8'((which == 0) ? done : done1), 8'(e.done));
      check($sformatf("%s_ready@%0t", w, $time), 8'((which == 0) ? req_ready : req_ready1), 8'(e.ready));
      check($sformatf("%s_err@%0t", w, $time), 8'((which == 0) ? err : err1), 8'(e.err));
`ifdef OPKEY_ECHO_CHECK_EN
      if (e.mm_chk)
        check($sformatf("%s_mismatch@%0t", w, $time), 8'((which == 0) ? mismatch : mismatch1), 8'(e.mm));
`endif
    end
  endtask

  task automatic run(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check_next(which);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;  req_opcode = 4'd0;
    req_valid1 = 1'b0; req_opcode1 = 4'd0;
    opcode_fb = 4'd0;  opcode_fb1 = 4'd0;

    // Reset state.
    #3;
    check("rst_key", 8'(key), 8'h0);
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_done", 8'(done), 8'h0);
    check("rst_err", 8'(err), 8'h0);
    check("rst_ready", 8'(req_ready), 8'h0);
    check("rst_mismatch", 8'(mismatch), 8'h0);
    #9 rst_n = 1'b1;
    step();
    check("ready_after_release", 8'(req_ready), 8'h1);
    check("small_ready_after_release", 8'(req_ready1), 8'h1);

    // Opcode 2 with default timing: press cycles 1-4, gap 5-6, done at 7.
    req_valid = 1'b1; req_opcode = 4'd2;
    push_seq(0, 4'd2, 4, 2, 1'b0, 1'b0);
    step(); req_valid = 1'b0; check_next(0);
    run(0, 6);

    // Opcode 9, then opcode 4 held valid through the busy period and accepted in the done cycle.
    req_valid = 1'b1; req_opcode = 4'd9;
    push_seq(0, 4'd9, 4, 2, 1'b0, 1'b0);
    push_seq(0, 4'd4, 4, 2, 1'b0, 1'b0);
    step(); req_opcode = 4'd4; check_next(0);
    run(0, 7);
    req_valid = 1'b0;
    run(0, 6);

    // Illegal opcodes, the second accepted while err is still high.
    req_valid = 1'b1; req_opcode = 4'd12;
    push(0, '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    push(0, '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    push(0, '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    push(0, '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    step(); req_opcode = 4'd13; check_next(0);
    step(); req_valid = 1'b0; check_next(0);
    run(0, 2);

    // Reset during the second press cycle of opcode 7.
    req_valid = 1'b1; req_opcode = 4'd7;
    push(0, '{4'b1100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    push(0, '{4'b1100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    step(); req_valid = 1'b0; check_next(0);
    run(0, 1);
    rst_n = 1'b0;
    #1;
    check("abort_key", 8'(key), 8'h0);
    check("abort_busy", 8'(busy), 8'h0);
    check("abort_ready", 8'(req_ready), 8'h0);
    check("abort_done", 8'(done), 8'h0);
    step(); step();
    check("in_reset_key", 8'(key), 8'h0);
    check("in_reset_done", 8'(done), 8'h0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push(0, '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    run(0, 4);
    req_valid = 1'b1; req_opcode = 4'd1;
    push_seq(0, 4'd1, 4, 2, 1'b0, 1'b0);
    step(); req_valid = 1'b0; check_next(0);
    run(0, 6);

    // PRESS_CYCLES=1, GAP_CYCLES=1 instance, opcode 0.
    req_valid1 = 1'b1; req_opcode1 = 4'd0;
    push_seq(1, 4'd0, 1, 1, 1'b0, 1'b0);
    step(); req_valid1 = 1'b0; check_next(1);
    run(1, 2);

`ifdef OPKEY_ECHO_CHECK_EN
    // Echo check: matching feedback, then wrong feedback.
    opcode_fb = 4'd5;
    req_valid = 1'b1; req_opcode = 4'd5;
    push_seq(0, 4'd5, 4, 2, 1'b1, 1'b0);
    step(); req_valid = 1'b0; check_next(0);
    run(0, 6);
    opcode_fb = 4'd0;
    req_valid = 1'b1; req_opcode = 4'd5;
    push_seq(0, 4'd5, 4, 2, 1'b1, 1'b1);
    step(); req_valid = 1'b0; check_next(0);
    run(0, 6);
`endif

    check("dut_queue_drained", 8'(q0.size()), 8'd0);
    check("small_queue_drained", 8'(q1.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/opcode_key_driver.md
OPCODE_KEY_DRIVER -- requirements
Module: opcode_key_driver

Interface
REQ-001 The block SHALL provide parameter PRESS_CYCLES, default 4, meaning the number of cycles the key pattern is held (legal 1..255).
REQ-002 The block SHALL provide parameter GAP_CYCLES, default 2, meaning the number of cycles key is held at 4'b0000 after a press (legal 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: an opcode request is present.
REQ-006 The block SHALL have port req_opcode, input, 4 bits: ALU opcode to convert into a key press.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-008 The block SHALL have port key, output, 4 bits: button pattern, active-high, for the operation selector.
REQ-009 The block SHALL have port busy, output, 1 bit: a press or gap is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when a press sequence completes.
REQ-011 The block SHALL have port err, output, 1 bit: one-cycle pulse when an accepted opcode is illegal.

Function
REQ-012 The block SHALL map opcodes to key patterns as follows: 0->0001, 1->0010, 2->0100, 3->1000, 4->0101, 5->0011, 6->0110, 7->1100, 8->0111, 9->1110.
REQ-013 Opcodes 10..15 SHALL be illegal.
REQ-014 The FSM SHALL have exactly three states: IDLE, PRESS and GAP.
REQ-015 req_ready SHALL be 1 only in IDLE; busy SHALL be 1 exactly in PRESS and GAP.
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_opcode is captured at that edge and ignored thereafter.
REQ-017 When a legal opcode is accepted, the FSM SHALL move IDLE->PRESS, and key SHALL show the mapped pattern from the cycle after acceptance for exactly PRESS_CYCLES cycles.
REQ-018 After PRESS, the FSM SHALL move PRESS->GAP, and key SHALL be 4'b0000 for exactly GAP_CYCLES cycles.
REQ-019 After GAP, the FSM SHALL move GAP->IDLE; done SHALL be 1 for exactly the first IDLE cycle, coincident with req_ready=1.
REQ-020 A back-to-back request accepted in that done cycle SHALL start its PRESS on the next cycle; the minimum request period is PRESS_CYCLES+GAP_CYCLES+1 cycles.
REQ-021 When an illegal opcode is accepted, the block SHALL stay in IDLE and key SHALL remain 4'b0000.
REQ-022 For an illegal opcode, err SHALL be 1 for the single cycle after acceptance, and done SHALL not pulse.
REQ-023 An illegal request accepted while err is high SHALL produce a further err pulse on the following cycle.
REQ-024 req_valid during PRESS or GAP SHALL be ignored; the requester holds it until req_ready=1.
REQ-025 The cycle counter SHALL be 8 bits, SHALL load (count-1) on each state entry, and SHALL decrement to 0; it SHALL not wrap.
REQ-026 key, done and err SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately force: state IDLE, key=0000, busy=0, done=0, err=0, counter=0.
REQ-028 req_ready SHALL be 0 while rst_n=0 and SHALL be 1 from the first clk edge after deassertion.
REQ-029 A reset asserted mid-PRESS or mid-GAP SHALL abort the sequence without a done pulse; the captured opcode is discarded.

Configuration
REQ-030 Macro OPKEY_ECHO_CHECK_EN SHALL control the echo check.
REQ-031 With OPKEY_ECHO_CHECK_EN defined, the block SHALL add input opcode_fb (4 bits) and output mismatch (1 bit, reset 0).
REQ-032 With the echo check compiled in, during the last PRESS cycle the block SHALL compare opcode_fb against the captured opcode; if they differ, mismatch SHALL be 1 during the next cycle; otherwise 0.
REQ-033 With OPKEY_ECHO_CHECK_EN undefined, neither port SHALL exist and the remaining behaviour SHALL be identical.

Verification
REQ-034 The bench SHALL cover: reset, then opcode 2 accepted at cycle 0 with default parameters -> key=0100 in cycles 1-4, 0000 in cycles 5-6, done=1 and req_ready=1 at cycle 7.
REQ-035 The bench SHALL cover: opcode 9, then opcode 4 presented in the done cycle -> key=1110 for 4 cycles, 0000 for 2 cycles, then 0101 starting the cycle after done.
REQ-036 The bench SHALL cover: opcode 12 accepted -> err=1 for the next cycle only, key stays 0000, busy=0, req_ready stays 1, no done.
REQ-037 The bench SHALL cover: rst_n=0 in the 2nd PRESS cycle of opcode 7 -> key=0000 immediately, no done ever, and a new request is accepted after release.
REQ-038 The bench SHALL cover: PRESS_CYCLES=1, GAP_CYCLES=1, opcode 0 -> key=0001 for 1 cycle, 0000 for 1 cycle, done on the 3rd cycle after acceptance.
REQ-039 The bench SHALL cover, with OPKEY_ECHO_CHECK_EN: opcode 5 with opcode_fb=5 -> mismatch stays 0; opcode 5 with opcode_fb=0 -> mismatch=1 for one cycle.
